// File: rtl/fb_word_streamer.sv
// Framebuffer port-B read sequencer: streams a run of words to a consumer,
// hiding the RAM's registered read latency behind a 2-entry output buffer.
module fb_word_streamer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_clk_enable,
  input  logic [DATA_W-1:0] ram_data_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CW = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic [CW-1:0]     deliv_q, deliv_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic              infl_q, infl_d;
  logic              valid_q, valid_d;

  logic              pop;
  logic              cap;
  logic              credit;
  logic              issue;
  logic [2:0]        pending;

  assign pop     = valid_q & out_ready;
  assign cap     = infl_q & ~abort;
  assign pending = {1'b0, occ_q} + {2'b00, infl_q};

  // A same-cycle pop frees a slot, but never issue while both slots are full.
  assign credit = (pending < 3'd2) | (pop & (occ_q != 2'd2));

  assign issue = (state_q == STREAM) & (issued_q != count_q)
               & credit & ~abort;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    issued_d = issued_q;
    deliv_d  = deliv_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_d  = STREAM;
            addr_d   = start_addr;
            count_d  = {1'b0, word_count};
            issued_d = '0;
            deliv_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + CW'(1);
          if (issued_d == count_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if ((state_q != IDLE) && pop) begin
      deliv_d = deliv_q + CW'(1);
      if (deliv_d == count_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ cap;
    rd_ptr_d = rd_ptr_q ^ pop;
    occ_d    = occ_q + {1'b0, cap} - {1'b0, pop};
    infl_d   = issue;
    valid_d  = (occ_d != 2'd0);
    if (abort) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
      infl_d   = 1'b0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      deliv_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      deliv_q  <= deliv_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      infl_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      if (cap) begin
        fifo_q[wr_ptr_q] <= ram_data_in;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      valid_q  <= valid_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign ram_addr       = addr_q;
  assign ram_clk_enable = issue;
  assign out_data       = fifo_q[rd_ptr_q];
  assign out_valid      = valid_q;

endmodule

// File: tb/tb_fb_word_streamer.sv
// Scoreboard bench for fb_word_streamer with a registered-read RAM model.
module tb_fb_word_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] start_addr = '0;
  logic [11:0] word_count = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [10:0] ram_addr;
  logic        ram_clk_enable;
  logic [15:0] ram_data_in = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  fb_word_streamer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_addr     (start_addr),
    .word_count     (word_count),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .ram_addr       (ram_addr),
    .ram_clk_enable (ram_clk_enable),
    .ram_data_in    (ram_data_in),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [2048];

  function automatic logic [15:0] word_at(input int a);
    if (a == 0) return 16'h4241;
    if (a == 1) return 16'h4443;
    return 16'hA000 | 16'(a);
  endfunction

  always @(posedge clk) begin
    if (ram_clk_enable) ram_data_in <= mem[ram_addr];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [15:0] exp_d [$];
  int          exp_a [$];
  int cyc = 0, start_cyc = 0, vrise_cyc = 0, acc_cyc = 0, done_cyc = 0;
  int done_cnt = 0, en_cnt = 0, held = 0;
  bit infl = 0, vprev = 0, busy_seen = 0, busy_at_done = 0, busy_at_acc = 0;
  int rdy_mode = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      exp_d.delete();
      exp_a.delete();
      held = 0;
      infl = 0;
      vprev = 0;
    end else begin
      if (start && !busy) start_cyc = cyc;
      if (out_valid && !vprev) vrise_cyc = cyc;
      vprev = out_valid;
      if (busy) busy_seen = 1;
      if (ram_clk_enable) begin
        en_cnt++;
        chk("credit_full", {31'd0, held == 2}, 0);
        if (exp_a.size() == 0) chk("spurious_rd", 1, 0);
        else chk("rd_addr", {21'd0, ram_addr}, exp_a.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) chk("extra_word", 1, 0);
        else chk("word", {16'd0, out_data}, {16'd0, exp_d.pop_front()});
        acc_cyc = cyc;
        busy_at_acc = busy;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (abort) begin
        held = 0;
        infl = 0;
        exp_d.delete();
        exp_a.delete();
      end else begin
        held = held + int'(infl) - int'(out_valid && out_ready);
        infl = ram_clk_enable;
      end
    end
  end

  initial begin
    automatic bit [3:0] pat = 4'b1001;
    automatic int idx = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[3 - (idx % 4)]; idx++; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic push_run(input int addr, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_a.push_back((addr + i) % 2048);
      exp_d.push_back(word_at((addr + i) % 2048));
    end
  endtask

  task automatic pulse_start(input int addr, input int cnt);
    @(posedge clk);
    #1;
    start_addr = 11'(addr);
    word_count = 12'(cnt);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input int addr, input int cnt, input int mode,
                     input bit restart);
    automatic int d0 = done_cnt;
    rdy_mode = mode;
    push_run(addr, cnt);
    pulse_start(addr, cnt);
    if (restart) begin
      repeat (2) @(posedge clk);
      #1;
      start_addr = 11'd100;
      word_count = 12'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int k = 0; k < 400 && done_cnt == d0; k++) @(negedge clk);
    chk("done_seen", done_cnt - d0, 1);
    chk("exp_left", exp_d.size() + exp_a.size(), 0);
    if (cnt > 0) begin
      chk("done_lat", done_cyc, acc_cyc + 1);
      chk("busy_at_acc", {31'd0, busy_at_acc}, 1);
      chk("busy_at_done", {31'd0, busy_at_done}, 0);
    end
    repeat (2) @(negedge clk);
    chk("one_done", done_cnt - d0, 1);
  endtask

  initial begin
    automatic int d0, e0;
    for (int k = 0; k < 2048; k++) mem[k] = word_at(k);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_outs", {1'b0, busy, done, ram_addr, ram_clk_enable,
                       out_data, out_valid}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_outs", {1'b0, busy, done, ram_addr, ram_clk_enable,
                      out_data, out_valid}, 0);

    // T1
    run(0, 2, 0, 0);
    chk("t1_first_valid", vrise_cyc, start_cyc + 3);
    chk("t1_tput", acc_cyc, vrise_cyc + 1);

    // T2
    run(0, 2, 1, 0);

    // T3
    run(2047, 3, 0, 0);

    // T4
    busy_seen = 0;
    e0 = en_cnt;
    run(5, 0, 0, 0);
    chk("t4_done_lat", done_cyc, start_cyc + 1);
    chk("t4_no_rd", en_cnt - e0, 0);
    chk("t4_busy", {31'd0, busy_seen}, 0);

    // T5
    d0 = done_cnt;
    rdy_mode = 3;
    push_run(10, 4);
    pulse_start(10, 4);
    for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
    chk("t5_valid_seen", {31'd0, out_valid}, 1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t5_valid_off", {31'd0, out_valid}, 0);
    chk("t5_busy_off", {31'd0, busy}, 0);
    repeat (6) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_no_rd", {31'd0, ram_clk_enable}, 0);
    run(0, 2, 0, 0);
    chk("t5_first_valid", vrise_cyc, start_cyc + 3);

    // start while busy, random backpressure, long run
    run(1990, 40, 2, 1);
    run(300, 25, 1, 1);

    // T6
    rdy_mode = 0;
    push_run(5, 4);
    pulse_start(5, 4);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_outs", {1'b0, busy, done, ram_addr, ram_clk_enable,
                          out_data, out_valid}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run(1, 3, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
